// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and result helpers for the
// matrix-multiplier datapath. DOT4_SATURATE_EN selects sat_res.
package matrix_pkg;

  localparam int DATA_W  = 16;
  localparam int N_TERMS = 4;
  localparam int SEL_W   = 4;
  localparam int RES_W   = 32;
  localparam int ACC_W   =
    2 * DATA_W + $clog2(N_TERMS);

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic logic [RES_W-1:0]
    wrap_res(input logic [ACC_W-1:0] v);
    return v[RES_W-1:0];
  endfunction

  // In range when every bit above the result
  // sign bit repeats the accumulator sign.
  function automatic logic [RES_W-1:0]
    sat_res(input logic [ACC_W-1:0] v);
    logic ok;
    ok = v[ACC_W-1:RES_W-1] ==
         {(ACC_W-RES_W+1){v[ACC_W-1]}};
    if (ok)
      return v[RES_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(RES_W-1){1'b0}}};
    else
      return {1'b0, {(RES_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/mac_unit_16.sv
// Signed multiply-accumulate: clk, rst, clr, en, a, b -> acc_nxt.
// acc_nxt is the sum including the current product.
import matrix_pkg::*;

module mac_unit_16 #(
  parameter int DW = matrix_pkg::DATA_W,
  parameter int AW = matrix_pkg::ACC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc_nxt
);

  logic [AW-1:0]   acc;
  logic [2*DW-1:0] ax;
  logic [2*DW-1:0] bx;
  logic [2*DW-1:0] prod;

  // Low 2*DW bits of the product of
  // sign-extended operands = signed product.
  assign ax   = {{DW{a[DW-1]}}, a};
  assign bx   = {{DW{b[DW-1]}}, b};
  assign prod = ax * bx;

  assign acc_nxt = acc +
    {{(AW-2*DW){prod[2*DW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc_nxt;
  end

endmodule

// File: rtl/dot4_mac_sequencer.sv
// Dot-product sequencer: drives sel, accumulates a_in*b_in,
// start/busy/done/result. Optional clamp: DOT4_SATURATE_EN.
import matrix_pkg::*;

module dot4_mac_sequencer #(
  parameter int DATA_W  = matrix_pkg::DATA_W,
  parameter int N_TERMS = matrix_pkg::N_TERMS,
  parameter int SEL_W   = matrix_pkg::SEL_W,
  parameter int RES_W   = matrix_pkg::RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam int AW    = 2 * DATA_W + CNT_W;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_idle;
  logic             is_run;
  logic             is_done;
  logic             acpt;
  logic             last;
  logic [AW-1:0]    acc_nxt;
  logic [RES_W-1:0] fin;

  assign is_idle = state == S_IDLE;
  assign is_run  = state == S_RUN;
  assign is_done = state == S_DONE;
  assign acpt    = start & (is_idle | is_done);
  assign last    = cnt == CNT_W'(N_TERMS - 1);

  // cnt is zero outside RUN, so sel needs
  // no extra gating.
  assign sel  = SEL_W'(cnt);
  assign busy = is_run;
  assign done = is_done;

`ifdef DOT4_SATURATE_EN
  assign fin = sat_res(acc_nxt);
`else
  assign fin = wrap_res(acc_nxt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (1'b1)
        is_run: begin
          if (last) begin
            state  <= S_DONE;
            cnt    <= '0;
            result <= fin;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        acpt: begin
          state <= S_RUN;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mac_unit_16 #(
    .DW (DATA_W),
    .AW (AW)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (acpt),
    .en      (is_run),
    .a       (a_in),
    .b       (b_in),
    .acc_nxt (acc_nxt)
  );

endmodule

// File: tb/tb_dot4_mac_sequencer.sv
// Bench for dot4_mac_sequencer: mux model, dot-product
// model and per-cycle compare plus literal expectations.
module tb_dot4_mac_sequencer;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  sel;
  logic        busy;
  logic        done;
  logic [31:0] result;

  logic [15:0] ma [NT];
  logic [15:0] mb [NT];

  int checks = 0;
  int errors = 0;

  int          ph = 0;
  logic [31:0] m_res = '0;
  logic [31:0] pend = '0;
  logic        cmp_en = 1'b0;
  int          dcnt = 0;
  int          bcnt = 0;

  always #5 clk = ~clk;

  dot4_mac_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .sel    (sel),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always_comb begin
    a_in = 16'hDEAD;
    b_in = 16'hBEEF;
    if (sel < 4'(NT)) begin
      a_in = ma[sel[1:0]];
      b_in = mb[sel[1:0]];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dot_exp();
    longint s = 0;
    for (int i = 0; i < NT; i++)
      s += longint'($signed(ma[i])) *
           longint'($signed(mb[i]));
`ifdef DOT4_SATURATE_EN
    if (s > 64'sh7FFFFFFF)
      s = 64'sh7FFFFFFF;
    else if (s < -64'sh80000000)
      s = -64'sh80000000;
`endif
    return s[31:0];
  endfunction

  // ph: 0 idle, 1..NT run term ph-1, NT+1 done.
  always @(posedge clk) begin
    if (rst) begin
      ph    = 0;
      m_res = '0;
    end else if (ph >= 1 && ph < NT) begin
      ph++;
    end else if (ph == NT) begin
      ph    = NT + 1;
      m_res = pend;
    end else if (start) begin
      ph   = 1;
      pend = dot_exp();
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic eb;
      eb = ph >= 1 && ph <= NT;
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ph == NT + 1));
      chk("sel", 32'(sel), eb ? 32'(ph - 1) : 0);
      chk("result", result, m_res);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
  end

  task automatic load(input logic [63:0] av,
                      input logic [63:0] bv);
    for (int i = 0; i < NT; i++) begin
      ma[i] = av[16*i +: 16];
      mb[i] = bv[16*i +: 16];
    end
  endtask

  task automatic dot(input string nm,
                     input logic [63:0] av,
                     input logic [63:0] bv,
                     input logic [31:0] er);
    load(av, bv);
    dcnt = 0;
    bcnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk(nm, result, er);
    chk({nm, "_dones"}, 32'(dcnt), 1);
    chk({nm, "_busy"}, 32'(bcnt), NT);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    load(64'h0, 64'h0);
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    dot("basic",
        64'h0004_0003_0002_0001,
        64'h0008_0007_0006_0005,
        32'd70);
    dot("signed",
        64'h0004_FFFD_0002_FFFF,
        64'h0008_0007_FFFA_0005,
        32'hFFFFFFFA);
`ifdef DOT4_SATURATE_EN
    dot("ovf", {4{16'h7FFF}}, {4{16'h7FFF}},
        32'h7FFFFFFF);
    dot("negx", {4{16'h8000}}, {4{16'h8000}},
        32'h7FFFFFFF);
`else
    dot("ovf", {4{16'h7FFF}}, {4{16'h7FFF}},
        32'hFFFC0004);
    dot("negx", {4{16'h8000}}, {4{16'h8000}},
        32'h00000000);
`endif

    // start held high: results every NT+1 cycles
    load(64'h0001_0001_0001_0001,
         64'h0002_0003_0004_0005);
    dcnt = 0;
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("b2b_dones", 32'(dcnt), 4);
    chk("b2b_result", result, 32'd14);

    // reset two cycles into a run
    load(64'h0004_0003_0002_0001,
         64'h0008_0007_0006_0005);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dcnt = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_sel", 32'(sel), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_result", result, 32'h0);
    repeat (6) @(negedge clk);
    chk("mid_nodone", 32'(dcnt), 0);

    dot("after_rst",
        64'h0004_0003_0002_0001,
        64'h0008_0007_0006_0005,
        32'd70);

    repeat (3) @(negedge clk);
    chk("held", result, 32'd70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
